// File: rtl/bitserial_logic16_pkg.sv
// Shared encodings for the bit-serial logic/add unit.
// Op codes, FSM states and the 1-bit carry majority helper.
package bitserial_logic16_pkg;

  localparam int unsigned WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_ADD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/bitserial_logic16_if.sv
// Operand/result handshake bundle for bitserial_logic16.
interface bitserial_logic16_if #(parameter int unsigned WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             busy;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, out, busy
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, out, busy
  );
endinterface

// File: rtl/bitserial_logic16_serial_op_cell.sv
// Combinational 1-bit slice: logic op or full-adder bit.
// carry_out is always the majority; the parent decides whether to keep it.
module serial_op_cell
  import bitserial_logic16_pkg::*;
(
  input  op_e  op,
  input  logic a_bit,
  input  logic b_bit,
  input  logic carry_in,
  output logic r,
  output logic carry_out
);

  always_comb begin
    r         = 1'b0;
    carry_out = maj3(a_bit, b_bit, carry_in);
    unique case (op)
      OP_AND:  r = a_bit & b_bit;
      OP_OR:   r = a_bit | b_bit;
      OP_XOR:  r = a_bit ^ b_bit;
      OP_ADD:  r = a_bit ^ b_bit ^ carry_in;
      default: r = 1'b0;
    endcase
  end

endmodule

// File: rtl/bitserial_logic16.sv
// Bit-serial AND/OR/XOR/ADD over WIDTH cycles, LSB first.
// Operands accepted in IDLE, result held in DONE until taken.
module bitserial_logic16
  import bitserial_logic16_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  bitserial_logic16_if.slave bus
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [WIDTH-1:0]   sa_q, sa_d;
  logic [WIDTH-1:0]   sb_q, sb_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               out_valid_q, out_valid_d;
  logic               r_bit;
  logic               carry_nxt;

  serial_op_cell u_cell (
    .op        (op_q),
    .a_bit     (sa_q[0]),
    .b_bit     (sb_q[0]),
    .carry_in  (carry_q),
    .r         (r_bit),
    .carry_out (carry_nxt)
  );

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    res_d       = res_q;
    out_d       = out_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          sa_d    = bus.a;
          sb_d    = bus.b;
          op_d    = op_e'(bus.op);
          res_d   = '0;
          cnt_d   = '0;
          carry_d = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        res_d = {r_bit, res_q[WIDTH-1:1]};
        cnt_d = CNT_W'(cnt_q + 1'b1);
        if (op_q == OP_ADD) carry_d = carry_nxt;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          out_d       = res_d;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= OP_AND;
      sa_q        <= '0;
      sb_q        <= '0;
      res_q       <= '0;
      out_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      res_q       <= res_d;
      out_q       <= out_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_bitserial_logic16.sv
// Directed bench for bitserial_logic16 with a transaction-level reference model.
module tb_bitserial_logic16;
  import bitserial_logic16_pkg::*;

  localparam int unsigned W = 16;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  bit   started;

  bitserial_logic16_if #(.WIDTH(W)) bus ();

  bitserial_logic16 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] golden(input logic [1:0] o, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
    case (o)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return W'(x + y);
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: result = arithmetic on captured operands, ready W edges after accept
  bit           m_pending, m_done;
  int           m_left;
  logic [W-1:0] m_res, m_out;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pending = 0; m_done = 0; m_left = 0; m_res = '0; m_out = '0;
    end else if (m_done) begin
      if (bus.out_ready) m_done = 0;
    end else if (m_pending) begin
      m_left--;
      if (m_left == 0) begin
        m_pending = 0; m_done = 1; m_out = m_res;
      end
    end else if (bus.in_valid) begin
      m_pending = 1; m_left = W; m_res = golden(bus.op, bus.a, bus.b);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("out_valid", 32'(bus.out_valid), 32'(m_done));
      check("out",       32'(bus.out),       32'(m_out));
      check("in_ready",  32'(bus.in_ready),  32'(!(m_pending || m_done)));
      check("busy",      32'(bus.busy),      32'(m_pending || m_done));
    end
  end

  task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] exp,
                        input int hold, input bit scramble);
    int lat;
    logic [W-1:0] held;
    @(posedge clk); #2;
    bus.in_valid = 1'b1; bus.a = x; bus.b = y; bus.op = o; bus.out_ready = 1'b0;
    @(posedge clk); #2;
    bus.in_valid = 1'b0;
    if (scramble) begin
      bus.a = ~x; bus.b = x ^ y; bus.op = o ^ 2'b01;
    end
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (bus.out_valid !== 1'b1) check({name, "_busy_run"}, 32'(bus.busy), 32'd1);
    end
    check({name, "_latency"}, 32'(lat), 32'd16);
    check({name, "_result"}, 32'(bus.out), 32'(exp));
    held = bus.out;
    for (int i = 0; i < hold; i++) begin
      if (i == 2) begin
        bus.in_valid = 1'b1; bus.a = 16'h5A5A; bus.b = 16'h0F0F; bus.op = OP_XOR;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk); #1;
      check({name, "_bp_valid"}, 32'(bus.out_valid), 32'd1);
      check({name, "_bp_stable"}, 32'(bus.out), 32'(held));
      check({name, "_bp_in_ready"}, 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check({name, "_release_valid"}, 32'(bus.out_valid), 32'd0);
    check({name, "_release_ready"}, 32'(bus.in_ready), 32'd1);
    check({name, "_out_kept"}, 32'(bus.out), 32'(exp));
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0; n_fail = 0; started = 0;
    rst_n = 1'b1;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = 2'b00; bus.out_ready = 1'b0;

    // Model pins
    check("golden_and", 32'(golden(OP_AND, 16'hF0F0, 16'hFF00)), 32'h0000F000);
    check("golden_add_wrap", 32'(golden(OP_ADD, 16'hFFFF, 16'h0001)), 32'h00000000);
    check("golden_xor", 32'(golden(OP_XOR, 16'h1234, 16'h00FF)), 32'h000012CB);

    #1 rst_n = 1'b0;
    #1;
    started = 1;
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_out", 32'(bus.out), 32'd0);
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_busy", 32'(bus.busy), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    run_op("and",     OP_AND, 16'hF0F0, 16'hFF00, 16'hF000, 0, 0);
    run_op("add_wrap", OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 0, 0);
    run_op("add",     OP_ADD, 16'h1234, 16'h4321, 16'h5555, 0, 0);
    run_op("xor",     OP_XOR, 16'h1234, 16'h00FF, 16'h12CB, 0, 0);
    run_op("or",      OP_OR,  16'h1234, 16'h00FF, 16'h12FF, 0, 0);
    run_op("bp",      OP_AND, 16'hF0F0, 16'hFF00, 16'hF000, 5, 0);
    run_op("stable",  OP_ADD, 16'h0F0F, 16'h00FF, 16'h100E, 0, 1);

    // Reset in the middle of a run
    @(posedge clk); #2;
    bus.in_valid = 1'b1; bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.op = OP_ADD;
    @(posedge clk); #2;
    bus.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrun_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrun_rst_busy", 32'(bus.busy), 32'd0);
    check("midrun_rst_out", 32'(bus.out), 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;

    run_op("after_rst", OP_AND, 16'hAAAA, 16'hFFFF, 16'hAAAA, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
